// File: rtl/core_mem_pkg.sv
// Shared types and default widths for the core memory arbiter.
package core_mem_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    localparam int AW_DEFAULT  = 20;
    localparam int DAW_DEFAULT = 10;

endpackage

// File: rtl/core_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU,
// with one outstanding transaction and a starvation guard for fetch.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int             AW         = AW_DEFAULT,
    parameter int             DAW        = DAW_DEFAULT,
    parameter logic [AW-1:0]  DATA_BASE  = AW'(20'h0_4000),
    parameter int             STARVE_MAX = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           if_req_i,
    input  logic [AW-1:0]  if_addr_i,
    output logic           if_gnt_o,
    output logic           if_rvalid_o,
    output logic [31:0]    if_rdata_o,
    input  logic           lsu_req_i,
    input  logic           lsu_we_i,
    input  logic [3:0]     lsu_be_i,
    input  logic [DAW-1:0] lsu_addr_i,
    input  logic [31:0]    lsu_wdata_i,
    output logic           lsu_gnt_o,
    output logic           lsu_rvalid_o,
    output logic [31:0]    lsu_rdata_o,
    output logic           mem_req_o,
    output logic           mem_we_o,
    output logic [3:0]     mem_be_o,
    output logic [AW-1:0]  mem_addr_o,
    output logic [31:0]    mem_wdata_o,
    input  logic           mem_ready_i,
    input  logic           mem_rvalid_i,
    input  logic [31:0]    mem_rdata_i,
    output logic           busy_o,
    output logic           proto_err_o
);

    localparam int            CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    arb_owner_e    owner_q, owner_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          proto_err_q, proto_err_d;
    logic          lsu_wins;
    logic          req_any;
    logic          gnt;

    // LSU normally has priority; fetch only overrides once it has lost STARVE_MAX times.
    assign lsu_wins = lsu_req_i && !(if_req_i && (starve_q == STARVE_LIM));

    assign mem_we_o    = lsu_wins ? lsu_we_i : 1'b0;
    assign mem_be_o    = lsu_wins ? lsu_be_i : 4'hF;
    assign mem_wdata_o = lsu_wins ? lsu_wdata_i : 32'h0;
    assign mem_addr_o  = lsu_wins ? (DATA_BASE + AW'(lsu_addr_i)) : if_addr_i;

    assign if_rdata_o  = mem_rdata_i;
    assign lsu_rdata_o = mem_rdata_i;
    assign busy_o      = (state_q == WAIT_RSP);
    assign proto_err_o = proto_err_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        proto_err_d  = proto_err_q;
        req_any      = 1'b0;
        gnt          = 1'b0;
        mem_req_o    = 1'b0;
        if_gnt_o     = 1'b0;
        lsu_gnt_o    = 1'b0;
        if_rvalid_o  = 1'b0;
        lsu_rvalid_o = 1'b0;

        case (state_q)
            IDLE: begin
                // Request/grant are combinational, so mask them while reset is held.
                req_any   = rst_ni && (if_req_i || lsu_req_i);
                gnt       = req_any && mem_ready_i;
                mem_req_o = req_any;
                if (gnt) begin
                    lsu_gnt_o = lsu_wins;
                    if_gnt_o  = !lsu_wins;
                    owner_d   = lsu_wins ? OWN_LSU : OWN_IF;
                    state_d   = WAIT_RSP;
                end
                if (mem_rvalid_i) begin
                    proto_err_d = 1'b1;
                end
                if (!if_req_i || if_gnt_o) begin
                    starve_d = '0;
                end else if (lsu_gnt_o && (starve_q != STARVE_LIM)) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            WAIT_RSP: begin
                if (!if_req_i) begin
                    starve_d = '0;
                end
                if (mem_rvalid_i) begin
                    if_rvalid_o  = (owner_q == OWN_IF);
                    lsu_rvalid_o = (owner_q == OWN_LSU);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scenario bench for core_mem_arbiter; expected responses queue on grant and are checked on rvalid.
module tb_core_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i;
    logic [19:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        lsu_req_i, lsu_we_i;
    logic [3:0]  lsu_be_i;
    logic [9:0]  lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_gnt_o, lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [19:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o, proto_err_o;

    typedef struct {
        logic        is_lsu;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    core_mem_arbiter #(
        .AW(20), .DAW(10), .DATA_BASE(20'h0_4000), .STARVE_MAX(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle_inputs();
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        lsu_req_i    = 1'b0;
        lsu_we_i     = 1'b0;
        lsu_be_i     = '0;
        lsu_addr_i   = '0;
        lsu_wdata_i  = '0;
        mem_ready_i  = 1'b1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        if_req_i  = 1'b1;
        lsu_req_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        total++;
        if ({mem_req_o, if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o, busy_o, proto_err_o} !== 7'b0)
            $display("FAIL reset_outputs: got %b want %b",
                     {mem_req_o, if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o, busy_o, proto_err_o}, 7'b0);
        else passed++;
        @(negedge clk_i);
        idle_inputs();
        rst_ni = 1'b1;
        #1;
        total++;
        if ({mem_req_o, busy_o} !== 2'b00)
            $display("FAIL reset_release_idle: got %b want %b", {mem_req_o, busy_o}, 2'b00);
        else passed++;
    endtask

    task automatic test_fetch_only();
        exp_t e;
        @(negedge clk_i);
        if_req_i  = 1'b1;
        if_addr_i = 20'h00010;
        #1;
        total++;
        if ({mem_req_o, if_gnt_o, lsu_gnt_o} !== 3'b110)
            $display("FAIL fetch_gnt: got %b want %b", {mem_req_o, if_gnt_o, lsu_gnt_o}, 3'b110);
        else passed++;
        total++;
        if ({mem_addr_o, mem_we_o, mem_be_o} !== {20'h00010, 1'b0, 4'hF})
            $display("FAIL fetch_mem_attr: got %h/%b/%h want 00010/0/f", mem_addr_o, mem_we_o, mem_be_o);
        else passed++;
        if (if_gnt_o) sb.push_back('{1'b0, 32'hDEADBEEF});
        @(negedge clk_i);
        if_req_i = 1'b0;
        #1;
        total++;
        if ({busy_o, mem_req_o} !== 2'b10)
            $display("FAIL fetch_wait: got %b want %b", {busy_o, mem_req_o}, 2'b10);
        else passed++;
        @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        #1;
        total++;
        if (sb.size() == 0) $display("FAIL fetch_sb: got empty queue want 1 entry");
        else begin
            e = sb.pop_front();
            if ({if_rvalid_o, lsu_rvalid_o} !== {!e.is_lsu, e.is_lsu} || if_rdata_o !== e.data)
                $display("FAIL fetch_rsp: got rv=%b%b rdata=%h want rv=%b%b rdata=%h",
                         if_rvalid_o, lsu_rvalid_o, if_rdata_o, !e.is_lsu, e.is_lsu, e.data);
            else passed++;
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        total++;
        if (busy_o !== 1'b0) $display("FAIL fetch_done: got busy=%b want 0", busy_o);
        else passed++;
    endtask

    task automatic test_lsu_write();
        exp_t e;
        @(negedge clk_i);
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'b1;
        lsu_be_i    = 4'b0011;
        lsu_addr_i  = 10'h3FF;
        lsu_wdata_i = 32'h1234_5678;
        #1;
        total++;
        if ({lsu_gnt_o, if_gnt_o} !== 2'b10)
            $display("FAIL lsu_gnt: got %b want %b", {lsu_gnt_o, if_gnt_o}, 2'b10);
        else passed++;
        total++;
        if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {20'h043FF, 1'b1, 4'b0011, 32'h1234_5678})
            $display("FAIL lsu_mem_attr: got %h/%b/%b/%h want 043ff/1/0011/12345678",
                     mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
        else passed++;
        if (lsu_gnt_o) sb.push_back('{1'b1, 32'h0000_0000});
        @(negedge clk_i);
        idle_inputs();
        mem_rvalid_i = 1'b1;
        #1;
        total++;
        if (sb.size() == 0) $display("FAIL lsu_sb: got empty queue want 1 entry");
        else begin
            e = sb.pop_front();
            if ({if_rvalid_o, lsu_rvalid_o} !== {!e.is_lsu, e.is_lsu} || lsu_rdata_o !== e.data)
                $display("FAIL lsu_ack: got rv=%b%b rdata=%h want rv=%b%b rdata=%h",
                         if_rvalid_o, lsu_rvalid_o, lsu_rdata_o, !e.is_lsu, e.is_lsu, e.data);
            else passed++;
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_starvation();
        exp_t        e;
        logic [31:0] d;
        logic        want_lsu;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
            if_req_i     = 1'b1;
            if_addr_i    = 20'h00100 + 20'(k);
            lsu_req_i    = 1'b1;
            lsu_we_i     = 1'b0;
            lsu_addr_i   = 10'(k);
            #1;
            want_lsu = (k % 5) != 4;
            total++;
            if ({lsu_gnt_o, if_gnt_o} !== {want_lsu, !want_lsu})
                $display("FAIL starve_grant_%0d: got lsu/if=%b%b want %b%b",
                         k, lsu_gnt_o, if_gnt_o, want_lsu, !want_lsu);
            else passed++;
            d = $urandom;
            if (lsu_gnt_o || if_gnt_o) sb.push_back('{want_lsu, d});
            @(negedge clk_i);
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = d;
            #1;
            total++;
            if ({mem_req_o, lsu_gnt_o, if_gnt_o} !== 3'b000)
                $display("FAIL starve_no_b2b_%0d: got req/gnt=%b want 000", k, {mem_req_o, lsu_gnt_o, if_gnt_o});
            else passed++;
            total++;
            if (sb.size() == 0) $display("FAIL starve_sb_%0d: got empty queue want 1 entry", k);
            else begin
                e = sb.pop_front();
                if ({if_rvalid_o, lsu_rvalid_o} !== {!e.is_lsu, e.is_lsu}
                    || (e.is_lsu ? lsu_rdata_o : if_rdata_o) !== e.data)
                    $display("FAIL starve_rsp_%0d: got rv=%b%b rdata=%h want rv=%b%b rdata=%h", k,
                             if_rvalid_o, lsu_rvalid_o, mem_rdata_i, !e.is_lsu, e.is_lsu, e.data);
                else passed++;
            end
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic test_ready_low();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            if_req_i    = 1'b1;
            lsu_req_i   = 1'b1;
            mem_ready_i = 1'b0;
            #1;
            total++;
            if ({mem_req_o, if_gnt_o, lsu_gnt_o} !== 3'b100)
                $display("FAIL ready_low_%0d: got req/ifg/lsug=%b want 100", k, {mem_req_o, if_gnt_o, lsu_gnt_o});
            else passed++;
        end
        @(negedge clk_i);
        mem_ready_i = 1'b1;
        #1;
        total++;
        if ({lsu_gnt_o, if_gnt_o} !== 2'b10)
            $display("FAIL ready_rise_gnt: got lsu/if=%b%b want 10", lsu_gnt_o, if_gnt_o);
        else passed++;
        if (lsu_gnt_o || if_gnt_o) sb.push_back('{1'b1, 32'h5A5A_0F0F});
        @(negedge clk_i);
        idle_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5A5A_0F0F;
        #1;
        total++;
        if (sb.size() == 0) $display("FAIL ready_sb: got empty queue want 1 entry");
        else begin
            e = sb.pop_front();
            if ({if_rvalid_o, lsu_rvalid_o} !== {!e.is_lsu, e.is_lsu} || lsu_rdata_o !== e.data)
                $display("FAIL ready_rsp: got rv=%b%b rdata=%h want rv=%b%b rdata=%h",
                         if_rvalid_o, lsu_rvalid_o, lsu_rdata_o, !e.is_lsu, e.is_lsu, e.data);
            else passed++;
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk_i);
        if_req_i  = 1'b1;
        if_addr_i = 20'h00123;
        #1;
        if (if_gnt_o) sb.push_back('{1'b0, 32'hCAFE_0001});
        @(negedge clk_i);
        if_req_i = 1'b0;
        @(negedge clk_i);
        if_req_i     = 1'b1;
        if_addr_i    = 20'h00124;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_0001;
        #1;
        total++;
        if ({if_gnt_o, busy_o} !== 2'b01)
            $display("FAIL b2b_same_cycle: got gnt/busy=%b want 01", {if_gnt_o, busy_o});
        else passed++;
        total++;
        if (sb.size() == 0) $display("FAIL b2b_sb1: got empty queue want 1 entry");
        else begin
            e = sb.pop_front();
            if ({if_rvalid_o, lsu_rvalid_o} !== {!e.is_lsu, e.is_lsu} || if_rdata_o !== e.data)
                $display("FAIL b2b_rsp1: got rv=%b%b rdata=%h want rv=%b%b rdata=%h",
                         if_rvalid_o, lsu_rvalid_o, if_rdata_o, !e.is_lsu, e.is_lsu, e.data);
            else passed++;
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        total++;
        if ({if_gnt_o, busy_o, mem_addr_o} !== {1'b1, 1'b0, 20'h00124})
            $display("FAIL b2b_next_gnt: got gnt/busy=%b%b addr=%h want 10 addr=00124", if_gnt_o, busy_o, mem_addr_o);
        else passed++;
        if (if_gnt_o) sb.push_back('{1'b0, 32'hCAFE_0002});
        @(negedge clk_i);
        if_req_i = 1'b0;
        #1;
        total++;
        if (busy_o !== 1'b1) $display("FAIL b2b_busy_again: got busy=%b want 1", busy_o);
        else passed++;
        @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_0002;
        #1;
        total++;
        if (sb.size() == 0) $display("FAIL b2b_sb2: got empty queue want 1 entry");
        else begin
            e = sb.pop_front();
            if ({if_rvalid_o, lsu_rvalid_o} !== {!e.is_lsu, e.is_lsu} || if_rdata_o !== e.data)
                $display("FAIL b2b_rsp2: got rv=%b%b rdata=%h want rv=%b%b rdata=%h",
                         if_rvalid_o, lsu_rvalid_o, if_rdata_o, !e.is_lsu, e.is_lsu, e.data);
            else passed++;
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset_mid_txn();
        @(negedge clk_i);
        lsu_req_i  = 1'b1;
        lsu_addr_i = 10'h005;
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        #1;
        total++;
        if ({busy_o, proto_err_o} !== 2'b10)
            $display("FAIL midrst_pre: got busy/perr=%b want 10", {busy_o, proto_err_o});
        else passed++;
        @(negedge clk_i);
        rst_ni   = 1'b0;
        if_req_i = 1'b1;
        #1;
        total++;
        if ({busy_o, mem_req_o, if_gnt_o, lsu_gnt_o} !== 4'b0000)
            $display("FAIL midrst_async: got busy/req/gnts=%b want 0000", {busy_o, mem_req_o, if_gnt_o, lsu_gnt_o});
        else passed++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle_inputs();
        @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0BAD_0BAD;
        #1;
        total++;
        if ({if_rvalid_o, lsu_rvalid_o} !== 2'b00)
            $display("FAIL late_rvalid_out: got rv=%b%b want 00", if_rvalid_o, lsu_rvalid_o);
        else passed++;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        total++;
        if ({proto_err_o, busy_o} !== 2'b10)
            $display("FAIL proto_err_set: got perr/busy=%b want 10", {proto_err_o, busy_o});
        else passed++;
        repeat (3) @(negedge clk_i);
        #1;
        total++;
        if (proto_err_o !== 1'b1) $display("FAIL proto_err_sticky: got %b want 1", proto_err_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_lsu_write();
        test_starvation();
        test_ready_low();
        test_back_to_back();
        test_reset_mid_txn();
        total++;
        if (sb.size() != 0) $display("FAIL sb_drained: got %0d entries want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
